acdc_run_ctrl: RTL and testbench
================================

Name: acdc_run_ctrl

Overview:
- Parametrised successor to the core's standalone run control: start/halt sequencing plus the single 16-bit cycle counter, generalised.
- Sequences core run state (IDLE, RUN, HALTED) and produces run and halt.
- Counts cycles, retired instructions and NUM_EVT generic event channels, each CNT_W wide and saturating.
- Counters are readable through a select/read-data port; a watchdog halt is available as an option. Sits at top level beside the fetch unit and decoder.

Parameters:
- CNT_W, 16: width of every counter.
- NUM_EVT, 4: number of generic event counter channels (1..8).
- MAX_CYCLES, 4096: watchdog limit in cycles; only used when WATCHDOG_EN is defined. Must be < 2^CNT_W.

Ports:
- CLK  input  1  clock, posedge only.
- start  input  1  synchronous active-high reset/init; clears all state.
- halt_req  input  1  halt request from the decoder (halt instruction retiring).
- instr_valid  input  1  one instruction retired this cycle.
- evt  input  NUM_EVT  per-channel event strobes (e.g. branch taken, mem write, overflow).
- rd_sel  input  4  counter select: 0 = cycle, 1 = instr, 2..NUM_EVT+1 = evt[rd_sel-2], others read 0.
- rd_data  output  CNT_W  selected counter value, combinational from registers.
- run  output  1  core enable; high only in RUN.
- halt  output  1  done flag; high only in HALTED.
- timeout  output  1  high in HALTED when the halt was caused by the watchdog.
- sat  output  1  sticky; set when any counter saturates.

Behaviour:
- All state is registered on posedge CLK. start is sampled synchronously and has priority over everything.
- Reset (start=1 at an edge), applied next edge:
  - state=IDLE, all counters=0, run=0, halt=0, timeout=0, sat=0.
  - Applies mid-RUN and in HALTED alike; in-flight halt_req, instr_valid and evt are discarded.
- State machine:
  - IDLE: first edge with start=0 -> RUN. Counters do not count in IDLE.
  - RUN: run=1. Each edge:
    - cycle_ct += 1.
    - instr_ct += instr_valid.
    - evt_ct[i] += evt[i].
    - If halt_req=1 -> HALTED with timeout=0.
  - HALTED: halt=1, run=0. All counters frozen. Stays until start=1. halt_req, instr_valid and evt are ignored.
- Latency:
  - halt rises on the edge that samples halt_req; run falls on that same edge.
  - The cycle that samples halt_req is itself counted: cycle_ct increments, and instr_valid/evt on that cycle are counted.
- Simultaneous events:
  - halt_req and instr_valid in the same cycle: instruction counted, then halt.
  - All event channels count independently in the same cycle.
- Arithmetic:
  - Counters are unsigned CNT_W and saturate at 2^CNT_W-1; no wrap.
  - On the edge a counter would exceed max, it holds max and sat is set. sat clears only on start.
- Read port:
  - rd_data reflects register state after the last edge; readable in any state.
  - rd_sel out of range -> 0.
- halt_req while in IDLE is ignored; the block still enters RUN next edge.

Optional Feature:
- Macro: ACDC_RUN_CTRL_WATCHDOG_EN.
- Defined: in RUN, on the edge where cycle_ct would reach MAX_CYCLES (post-increment value == MAX_CYCLES) and halt_req=0, go to HALTED with timeout=1.
  - If halt_req=1 on that same edge, a normal halt is taken and timeout=0.
  - cycle_ct ends at MAX_CYCLES.
- Not defined: no watchdog, and timeout is tied to 0.

Test Plan:
- start=1 for 2 cycles, then 0 -> run=1 one edge later; halt=0; rd_sel=0 reads 0 while in IDLE. After 10 RUN cycles with halt_req=0, rd_data=10.
- 5 instr_valid pulses and 3 evt[1] pulses in RUN, then halt_req=1 with instr_valid=1 -> halt=1 and run=0 same edge; instr count=6, evt[1]=3 (rd_sel=3), cycle count frozen thereafter for 20 cycles.
- CNT_W=4, evt[0] held high 20 cycles -> rd_sel=2 reads 15, sat=1; other counters unaffected except cycle_ct, which also saturates at 15.
- start=1 pulse mid-RUN at cycle 7 -> all counters 0, sat=0, state IDLE, then RUN again; a halt_req held during start is ignored.
- With ACDC_RUN_CTRL_WATCHDOG_EN, MAX_CYCLES=8, no halt_req -> halt=1 and timeout=1 after 8 RUN edges, cycle count=8. Repeat with halt_req on the 8th edge -> timeout=0.
- rd_sel=NUM_EVT+2 and rd_sel=15 -> rd_data=0 in every state.

Source files
------------

// File: rtl/acdc_run_ctrl.sv
// Core run control: IDLE/RUN/HALTED sequencing with saturating cycle, instruction and event counters.
// Optional watchdog halt enabled by defining ACDC_RUN_CTRL_WATCHDOG_EN.
module acdc_run_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned NUM_EVT    = 4,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic               CLK,
   input  logic               start,
   input  logic               halt_req,
   input  logic               instr_valid,
   input  logic [NUM_EVT-1:0] evt,
   input  logic [3:0]         rd_sel,
   output logic [CNT_W-1:0]   rd_data,
   output logic               run,
   output logic               halt,
   output logic               timeout,
   output logic               sat
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALTED
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (NUM_EVT < 1 || NUM_EVT > 8) begin : g_bad_num_evt
      $error("acdc_run_ctrl: NUM_EVT must be in 1..8");
   end
   if (64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_max_cycles
      $error("acdc_run_ctrl: MAX_CYCLES must be below 2**CNT_W");
   end

   state_t           state;
   logic [CNT_W-1:0] cycle_ct;
   logic [CNT_W-1:0] instr_ct;
   logic [CNT_W-1:0] evt_ct   [NUM_EVT];

   logic [CNT_W-1:0] cyc_next;
   logic [CNT_W-1:0] instr_next;
   logic [CNT_W-1:0] evt_next [NUM_EVT];
   logic             cyc_hit;
   logic             instr_hit;
   logic [NUM_EVT-1:0] evt_hit;
   logic             any_hit;

   // A counter already at max that is asked to increment holds and flags saturation.
   always_comb begin
      cyc_hit    = (cycle_ct == CNT_MAX);
      cyc_next   = cyc_hit ? cycle_ct : cycle_ct + CNT_ONE;
      instr_hit  = instr_valid && (instr_ct == CNT_MAX);
      instr_next = (instr_valid && !instr_hit) ? instr_ct + CNT_ONE : instr_ct;
      evt_hit    = '0;
      evt_next   = evt_ct;
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
         evt_hit[i]  = evt[i] && (evt_ct[i] == CNT_MAX);
         evt_next[i] = (evt[i] && !evt_hit[i]) ? evt_ct[i] + CNT_ONE : evt_ct[i];
      end
      any_hit = cyc_hit || instr_hit || (|evt_hit);
   end

`ifdef ACDC_RUN_CTRL_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);
   logic wd_hit;

   assign wd_hit = (cyc_next == WD_LIMIT);

   // timeout can only rise on the RUN->HALTED edge, and HALTED is left only via start.
   always_ff @(posedge CLK) begin
      if (start) begin
         timeout <= 1'b0;
      end else if (state == ST_RUN && !halt_req && wd_hit) begin
         timeout <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (start) begin
         state    <= ST_IDLE;
         run      <= 1'b0;
         halt     <= 1'b0;
         sat      <= 1'b0;
         cycle_ct <= '0;
         instr_ct <= '0;
         for (int unsigned i = 0; i < NUM_EVT; i++) begin
            evt_ct[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_RUN;
               run   <= 1'b1;
               halt  <= 1'b0;
            end
            ST_RUN: begin
               cycle_ct <= cyc_next;
               instr_ct <= instr_next;
               for (int unsigned i = 0; i < NUM_EVT; i++) begin
                  evt_ct[i] <= evt_next[i];
               end
               sat <= sat || any_hit;
               if (halt_req) begin
                  state <= ST_HALTED;
                  run   <= 1'b0;
                  halt  <= 1'b1;
               end
`ifdef ACDC_RUN_CTRL_WATCHDOG_EN
               else if (wd_hit) begin
                  state <= ST_HALTED;
                  run   <= 1'b0;
                  halt  <= 1'b1;
               end
`endif
            end
            ST_HALTED: begin
               run  <= 1'b0;
               halt <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               run   <= 1'b0;
               halt  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_sel == 4'd0) begin
         rd_data = cycle_ct;
      end else if (rd_sel == 4'd1) begin
         rd_data = instr_ct;
      end else begin
         for (int unsigned i = 0; i < NUM_EVT; i++) begin
            if (rd_sel == 4'(i + 2)) begin
               rd_data = evt_ct[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_acdc_run_ctrl.sv
// Directed bench for acdc_run_ctrl: main instance, narrow saturating instance and short watchdog instance.
module tb_acdc_run_ctrl;

   logic        CLK = 1'b0;
   logic        start;
   logic        halt_req;
   logic        instr_valid;
   logic [3:0]  evt;
   logic [3:0]  rd_sel;

   logic [15:0] m_rd;
   logic        m_run, m_halt, m_timeout, m_sat;
   logic [3:0]  s_rd;
   logic        s_run, s_halt, s_timeout, s_sat;
   logic [15:0] w_rd;
   logic        w_run, w_halt, w_timeout, w_sat;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   acdc_run_ctrl #(.CNT_W(16), .NUM_EVT(4), .MAX_CYCLES(4096)) u_m (
      .CLK(CLK), .start(start), .halt_req(halt_req), .instr_valid(instr_valid),
      .evt(evt), .rd_sel(rd_sel), .rd_data(m_rd), .run(m_run), .halt(m_halt),
      .timeout(m_timeout), .sat(m_sat)
   );

   acdc_run_ctrl #(.CNT_W(4), .NUM_EVT(4), .MAX_CYCLES(15)) u_s (
      .CLK(CLK), .start(start), .halt_req(halt_req), .instr_valid(instr_valid),
      .evt(evt), .rd_sel(rd_sel), .rd_data(s_rd), .run(s_run), .halt(s_halt),
      .timeout(s_timeout), .sat(s_sat)
   );

   acdc_run_ctrl #(.CNT_W(16), .NUM_EVT(4), .MAX_CYCLES(8)) u_w (
      .CLK(CLK), .start(start), .halt_req(halt_req), .instr_valid(instr_valid),
      .evt(evt), .rd_sel(rd_sel), .rd_data(w_rd), .run(w_run), .halt(w_halt),
      .timeout(w_timeout), .sat(w_sat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rd_m(input string tag, input logic [3:0] sel, input logic [31:0] exp);
      rd_sel = sel;
      #1;
      chk(tag, 32'(m_rd), exp);
   endtask

   task automatic rd_s(input string tag, input logic [3:0] sel, input logic [31:0] exp);
      rd_sel = sel;
      #1;
      chk(tag, 32'(s_rd), exp);
   endtask

   task automatic rd_w(input string tag, input logic [3:0] sel, input logic [31:0] exp);
      rd_sel = sel;
      #1;
      chk(tag, 32'(w_rd), exp);
   endtask

   initial begin
      start = 1'b1; halt_req = 1'b0; instr_valid = 1'b0; evt = 4'b0000; rd_sel = 4'd0;

      // reset held two edges, then into RUN
      steps(2);
      chk("rst_run", 32'(m_run), 0);
      chk("rst_halt", 32'(m_halt), 0);
      chk("rst_timeout", 32'(m_timeout), 0);
      chk("rst_sat", 32'(m_sat), 0);
      rd_m("idle_cyc", 4'd0, 0);
      rd_m("idle_sel6", 4'd6, 0);
      rd_m("idle_sel15", 4'd15, 0);
      start = 1'b0;
      step();
      chk("run_rise", 32'(m_run), 1);
      chk("run_halt0", 32'(m_halt), 0);
      rd_m("run_cyc0", 4'd0, 0);
      steps(10);
      rd_m("run_cyc10", 4'd0, 10);
      rd_m("run_sel6", 4'd6, 0);
      rd_m("run_sel15", 4'd15, 0);

      // instructions and evt[1], then halt with a simultaneous retire
      for (int i = 0; i < 5; i++) begin
         instr_valid = 1'b1;
         evt = (i < 3) ? 4'b0010 : 4'b0000;
         step();
      end
      halt_req = 1'b1; instr_valid = 1'b1; evt = 4'b0000;
      step();
      chk("halt_rise", 32'(m_halt), 1);
      chk("halt_run0", 32'(m_run), 0);
      chk("halt_to0", 32'(m_timeout), 0);
      rd_m("halt_cyc", 4'd0, 16);
      rd_m("halt_instr", 4'd1, 6);
      rd_m("halt_evt1", 4'd3, 3);
      rd_m("halt_evt0", 4'd2, 0);
      halt_req = 1'b0; instr_valid = 1'b1; evt = 4'b1111;
      steps(20);
      chk("frz_halt", 32'(m_halt), 1);
      rd_m("frz_cyc", 4'd0, 16);
      rd_m("frz_instr", 4'd1, 6);
      rd_m("frz_evt1", 4'd3, 3);
      rd_m("frz_evt0", 4'd2, 0);
      rd_m("frz_sel6", 4'd6, 0);
      rd_m("frz_sel15", 4'd15, 0);
      chk("frz_sat", 32'(m_sat), 0);

      // restart, then start pulse mid-RUN with halt_req asserted alongside
      start = 1'b1; instr_valid = 1'b0; evt = 4'b0000;
      step();
      chk("rs_halt0", 32'(m_halt), 0);
      chk("rs_run0", 32'(m_run), 0);
      rd_m("rs_cyc", 4'd0, 0);
      start = 1'b0;
      step();
      instr_valid = 1'b1;
      steps(7);
      rd_m("mid_cyc7", 4'd0, 7);
      rd_m("mid_instr7", 4'd1, 7);
      start = 1'b1; halt_req = 1'b1; instr_valid = 1'b1; evt = 4'b1111;
      step();
      chk("mid_run0", 32'(m_run), 0);
      chk("mid_halt0", 32'(m_halt), 0);
      chk("mid_sat0", 32'(m_sat), 0);
      rd_m("mid_cyc0", 4'd0, 0);
      rd_m("mid_instr0", 4'd1, 0);
      rd_m("mid_evt0", 4'd2, 0);
      start = 1'b0;
      step();
      chk("idle_hr_run", 32'(m_run), 1);
      chk("idle_hr_halt", 32'(m_halt), 0);
      rd_m("idle_hr_cyc", 4'd0, 0);
      rd_m("idle_hr_instr", 4'd1, 0);
      halt_req = 1'b0; instr_valid = 1'b0; evt = 4'b0000;
      step();
      rd_m("after_cyc1", 4'd0, 1);
      chk("after_run", 32'(m_run), 1);

      // 4-bit counters saturate
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      evt = 4'b0001;
      steps(15);
`ifndef ACDC_RUN_CTRL_WATCHDOG_EN
      chk("s_sat_pre", 32'(s_sat), 0);
      rd_s("s_evt0_15", 4'd2, 15);
      rd_s("s_cyc_15", 4'd0, 15);
      steps(5);
      chk("s_sat", 32'(s_sat), 1);
      chk("s_run", 32'(s_run), 1);
      rd_s("s_evt0_sat", 4'd2, 15);
      rd_s("s_cyc_sat", 4'd0, 15);
      rd_s("s_instr", 4'd1, 0);
      rd_s("s_evt1", 4'd3, 0);
`else
      chk("s_wd_halt", 32'(s_halt), 1);
      chk("s_wd_to", 32'(s_timeout), 1);
      rd_s("s_wd_cyc", 4'd0, 15);
`endif
      start = 1'b1; evt = 4'b0000;
      step();
      chk("s_sat_clr", 32'(s_sat), 0);
      rd_s("s_evt0_clr", 4'd2, 0);

      // watchdog instance, MAX_CYCLES=8
      start = 1'b0;
      step();
      steps(8);
`ifdef ACDC_RUN_CTRL_WATCHDOG_EN
      chk("wd_halt", 32'(w_halt), 1);
      chk("wd_to", 32'(w_timeout), 1);
      chk("wd_run0", 32'(w_run), 0);
      rd_w("wd_cyc8", 4'd0, 8);
      steps(3);
      chk("wd_halt_hold", 32'(w_halt), 1);
      rd_w("wd_cyc_frz", 4'd0, 8);
`else
      chk("nowd_run", 32'(w_run), 1);
      chk("nowd_halt", 32'(w_halt), 0);
      chk("nowd_to", 32'(w_timeout), 0);
      rd_w("nowd_cyc8", 4'd0, 8);
      steps(2);
      rd_w("nowd_cyc10", 4'd0, 10);
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      steps(7);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("wdh_halt", 32'(w_halt), 1);
      chk("wdh_to0", 32'(w_timeout), 0);
      rd_w("wdh_cyc8", 4'd0, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
